// File: rtl/ps2_receiver.sv
// ps2_receiver: synchronized, glitch-filtered PS/2 device-to-host byte receiver
// with odd-parity/stop-bit checking and an inter-edge timeout.
module ps2_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_ready,
    output logic       frame_error
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic {IDLE, RECEIVE} state_t;
    state_t          state_q, state_d;
    logic [1:0]      pclk_q, pclk_d, pdat_q, pdat_d;
    logic            filt_q, filt_d, par_q, par_d, ready_q, ready_d, err_q, err_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d, code_q, code_d;
    logic [TW-1:0]   to_q, to_d;
    logic            fall, sdat;
    always_comb begin
        pclk_d    = {pclk_q[0], ps2_clk};
        pdat_d    = {pdat_q[0], ps2_data};
        sdat      = pdat_q[1];
        fcnt_d    = '0;
        filt_d    = filt_q;
        fall      = 1'b0;
        // filtered level flips on the FILTER_LEN-th consecutive differing sample
        if (pclk_q[1] != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = pclk_q[1];
                fall   = filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        code_d    = code_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        to_d      = (fall || state_q == IDLE) ? '0 : to_q + 1'b1;
        if (state_q == IDLE) begin
            if (fall && !sdat) begin
                state_d   = RECEIVE;
                bit_cnt_d = 4'd1;
                shift_d   = '0;
            end
        end else if (fall) begin
            if (bit_cnt_q <= 4'd8) begin
                shift_d   = {sdat, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd9) begin
                par_d     = sdat;
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                ready_d   = sdat && ^{shift_q, par_q};
                err_d     = !ready_d;
                code_d    = ready_d ? shift_q : code_q;
            end
        end else if (to_q == TW'(TIMEOUT_CYCLES)) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            err_d     = 1'b1;
            to_d      = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pclk_q    <= 2'b11;
            pdat_q    <= 2'b11;
            filt_q    <= 1'b1;
            fcnt_q    <= '0;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            to_q      <= '0;
            code_q    <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pclk_q    <= pclk_d;
            pdat_q    <= pdat_d;
            filt_q    <= filt_d;
            fcnt_q    <= fcnt_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            to_q      <= to_d;
            code_q    <= code_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end
    assign scan_code   = code_q;
    assign scan_ready  = ready_q;
    assign frame_error = err_q;
endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver: table-driven, hand-written and randomized PS/2 frames checked
// against a frame-level model (odd parity over data+parity, stop must be 1).
module tb_ps2_receiver;
    localparam int FL   = 8;
    localparam int TO   = 2000;
    localparam int HALF = 20;
    logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [7:0] scan_code;
    logic scan_ready, frame_error;
    int total = 0, passed = 0;
    int rdy_cnt = 0, err_cnt = 0, bad_cnt = 0;
    logic rdy_prev = 1'b0;
    logic [7:0] exp_code = 8'h00;

    ps2_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .scan_code(scan_code), .scan_ready(scan_ready), .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    // pulse monitor: counts events, flags overlaps and back-to-back ready cycles
    always @(negedge clk) begin
        if (!reset) begin
            if (scan_ready) rdy_cnt <= rdy_cnt + 1;
            if (frame_error) err_cnt <= err_cnt + 1;
            if ((scan_ready && frame_error) || (scan_ready && rdy_prev)) bad_cnt <= bad_cnt + 1;
            rdy_prev <= scan_ready;
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         exp_rdy;
        int         exp_err;
        logic [7:0] exp_code;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic glitch();
        repeat (HALF / 2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (FL - 2) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] d, input logic p, input logic s, input int nbits, input int glitch_at);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_bit(bits[i]);
            if (i == glitch_at) glitch();
        end
        ps2_data = 1'b1;
        repeat (3 * HALF) @(negedge clk);
    endtask

    task automatic frame_chk(input string name, input logic [7:0] d, input logic p, input logic s,
                             input int exp_rdy, input int exp_err, input logic [7:0] code, input int glitch_at);
        int r0, e0;
        r0 = rdy_cnt;
        e0 = err_cnt;
        send(d, p, s, 11, glitch_at);
        chk({name, " ready"}, rdy_cnt - r0, exp_rdy);
        chk({name, " error"}, err_cnt - e0, exp_err);
        chk({name, " code"}, {24'h0, scan_code}, {24'h0, code});
    endtask

    initial begin
        vec_t vt[8];
        int r0, e0;
        vt[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C};
        vt[1] = '{8'hF0, 1'b1, 1'b1, 1, 0, 8'hF0};
        vt[2] = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'hF0};
        vt[3] = '{8'h29, 1'b0, 1'b0, 0, 1, 8'hF0};
        vt[4] = '{8'h00, 1'b1, 1'b1, 1, 0, 8'h00};
        vt[5] = '{8'hFF, 1'b1, 1'b1, 1, 0, 8'hFF};
        vt[6] = '{8'h5A, 1'b1, 1'b1, 1, 0, 8'h5A};
        vt[7] = '{8'hFF, 1'b0, 1'b1, 0, 1, 8'h5A};

        repeat (5) @(negedge clk);
        chk("reset code", {24'h0, scan_code}, 32'h0);
        chk("reset ready", {31'h0, scan_ready}, 32'h0);
        chk("reset error", {31'h0, frame_error}, 32'h0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        for (int i = 0; i < 8; i++)
            frame_chk($sformatf("vec%0d", i), vt[i].data, vt[i].par, vt[i].stop,
                      vt[i].exp_rdy, vt[i].exp_err, vt[i].exp_code, -1);

        // two back-to-back good frames separated by an idle gap
        frame_chk("pair F0", 8'hF0, 1'b1, 1'b1, 1, 0, 8'hF0, -1);
        repeat (500) @(negedge clk);
        frame_chk("pair 1C", 8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, -1);
        exp_code = 8'h1C;

        // timeout after start + 4 data bits
        r0 = rdy_cnt;
        e0 = err_cnt;
        send(8'h29, 1'b0, 1'b1, 5, -1);
        repeat (TO + 100) @(negedge clk);
        chk("timeout error", err_cnt - e0, 1);
        chk("timeout ready", rdy_cnt - r0, 0);
        chk("timeout code", {24'h0, scan_code}, {24'h0, exp_code});
        frame_chk("after timeout", 8'h29, 1'b0, 1'b1, 1, 0, 8'h29, -1);

        // short clock glitches in idle and mid-frame are ignored
        r0 = rdy_cnt;
        e0 = err_cnt;
        glitch();
        repeat (50) @(negedge clk);
        chk("idle glitch events", (rdy_cnt - r0) + (err_cnt - e0), 0);
        frame_chk("midframe glitch", 8'h1C, 1'b0, 1'b1, 1, 0, 8'h1C, 3);

        // reset mid-frame after data bit 5
        e0 = err_cnt;
        send(8'h5A, 1'b1, 1'b1, 6, -1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset code", {24'h0, scan_code}, 32'h0);
        chk("midreset ready", {31'h0, scan_ready}, 32'h0);
        chk("midreset error", {31'h0, frame_error}, 32'h0);
        reset = 1'b0;
        repeat (TO + 100) @(negedge clk);
        chk("midreset no error", err_cnt - e0, 0);
        frame_chk("after reset", 8'h5A, 1'b1, 1'b1, 1, 0, 8'h5A, -1);
        exp_code = 8'h5A;

        // randomized frames against the frame-level model
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            logic p, s, ok;
            d = 8'($urandom_range(0, 255));
            p = ~^d;
            if ($urandom_range(0, 3) == 0) p = ~p;
            s = ($urandom_range(0, 7) != 0);
            ok = s && ($countones({d, p}) % 2 == 1);
            if (ok) exp_code = d;
            frame_chk($sformatf("rand%0d", i), d, p, s, ok ? 1 : 0, ok ? 0 : 1, exp_code, -1);
            repeat ($urandom_range(0, 100)) @(negedge clk);
        end

        chk("no overlap or adjacent ready", bad_cnt, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
